// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller and the pipeline register banks:
// sequencer states, default register-address width, bubble control word and jump kinds.
package pipe_ctrl_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Control word carried by the pipeline register banks; a bubble loads NOP_CTRL.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
    } stage_ctrl_t;

    localparam stage_ctrl_t NOP_CTRL = '0;

    typedef enum logic [1:0] {
        JT_NONE     = 2'd0,
        JT_BRANCH   = 2'd1,
        JT_JUMP     = 2'd2,
        JT_JUMP_REG = 2'd3
    } jump_type_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: the ID instruction needs a register that the
// load currently in EX has not produced yet. Register 0 never creates a hazard.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_write_reg,
    input  logic              ex_mem_to_reg,
    output logic              hazard
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_uses_rs && (id_rs == ex_write_reg);
    assign rt_hit = id_uses_rt && (id_rt == ex_write_reg);
    assign hazard = ex_mem_to_reg && (ex_write_reg != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freeze, redirect flush,
// load-use bubble, saturating stall counter and sticky memory-timeout error.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW      = REG_AW_DEF,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_write_reg,
    input  logic              ex_mem_to_reg,
    input  logic              mem_mem_access,
    input  logic              mem_redirect,
    input  logic              dmem_ack,
    output logic              dmem_req,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              hold_mem,
    output logic              bubble_wb,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem,
    output logic [CNT_W-1:0]  stall_count,
    output logic              mem_error
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t          state_reg, state_next;
    logic [TW-1:0]   tcnt_reg, tcnt_next;
    logic [CNT_W-1:0] stall_count_reg;
    logic            mem_error_reg;
    logic            load_use;
    logic            timeout_hit;
    logic            mem_stall;
    logic            redirect_act;
    logic            load_use_act;

    load_use_detect #(.REG_AW(REG_AW)) u_load_use (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .ex_write_reg (ex_write_reg),
        .ex_mem_to_reg(ex_mem_to_reg),
        .hazard       (load_use)
    );

    assign timeout_hit = (state_reg == MEM_WAIT) && !dmem_ack && (tcnt_reg == TW'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            tcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            tcnt_reg  <= tcnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tcnt_next  = tcnt_reg;
        case (state_reg)
            RUN: begin
                if (mem_mem_access && !dmem_ack) begin
                    state_next = MEM_WAIT;
                    tcnt_next  = TW'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ack || timeout_hit) begin
                    state_next = RUN;
                end else begin
                    tcnt_next = tcnt_reg + TW'(1);
                end
            end
            default: state_next = RUN;
        endcase
    end

    // The ack cycle and the timeout release cycle are unstalled, so a redirect or
    // load-use seen then is acted on like in RUN.
    always_comb begin
        mem_stall = (state_reg == RUN) ? (mem_mem_access && !dmem_ack)
                                       : (!dmem_ack && !timeout_hit);
        redirect_act = !mem_stall && mem_redirect;
        load_use_act = !mem_stall && !mem_redirect && load_use;

        dmem_req     = (state_reg == MEM_WAIT) || mem_mem_access;
        stall_if     = mem_stall || load_use_act;
        stall_id     = mem_stall || load_use_act;
        bubble_ex    = load_use_act;
        hold_mem     = mem_stall;
        bubble_wb    = mem_stall;
        flush_if_id  = redirect_act;
        flush_id_ex  = redirect_act;
        flush_ex_mem = redirect_act;

        if (!rst_n) begin
            dmem_req     = 1'b0;
            stall_if     = 1'b0;
            stall_id     = 1'b0;
            bubble_ex    = 1'b0;
            hold_mem     = 1'b0;
            bubble_wb    = 1'b0;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_reg <= '0;
            mem_error_reg   <= 1'b0;
        end else begin
            if (stall_if && (stall_count_reg != {CNT_W{1'b1}})) begin
                stall_count_reg <= stall_count_reg + CNT_W'(1);
            end
            if (timeout_hit) begin
                mem_error_reg <= 1'b1;
            end
        end
    end

    assign stall_count = stall_count_reg;
    assign mem_error   = mem_error_reg;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB register banks).
- Detects load-use hazards in ID.
- Applies branch/jump redirect flushes resolved in MEM.
- Freezes the pipeline while the data memory completes a variable-latency access over a req/ack handshake.
- Keeps a stall-cycle performance counter and a sticky memory-timeout error.

Parameters:
REG_AW, 5, register-address width
CNT_W, 16, stall counter width
MEM_TIMEOUT, 64, max cycles waiting for dmem_ack before error release (>=2)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
id_rs  in  REG_AW  source reg A of instruction in ID
id_rt  in  REG_AW  source reg B of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_write_reg  in  REG_AW  destination reg of instruction in EX
ex_mem_to_reg  in  1  EX instruction is a load
mem_mem_access  in  1  MEM instruction is load or store
mem_redirect  in  1  MEM instruction is a taken branch/jump
dmem_ack  in  1  data memory completes current access
dmem_req  out  1  data memory access request
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID
bubble_ex  out  1  load NOP into ID/EX
hold_mem  out  1  hold ID/EX and EX/MEM
bubble_wb  out  1  load NOP into MEM/WB
flush_if_id  out  1  clear IF/ID
flush_id_ex  out  1  clear ID/EX
flush_ex_mem  out  1  clear EX/MEM
stall_count  out  CNT_W  saturating count of stalled cycles
mem_error  out  1  sticky: a memory access timed out

Behaviour:
- FSM states: RUN, MEM_WAIT. Timeout counter: width clog2(MEM_TIMEOUT+1).
- Reset (rst_n low, asynchronous):
  - State RUN, timeout counter 0, stall_count 0, mem_error 0.
  - Combinational outputs are forced: dmem_req 0, all stall/hold/bubble 0, all flush_* 1.
- Control outputs are combinational from state and inputs. stall_count and mem_error are registered.
- RUN:
  - dmem_req = mem_mem_access.
  - Access with dmem_ack=1 in the same cycle: zero-wait access, no stall.
  - Access with dmem_ack=0: assert stall_if, stall_id, hold_mem, bubble_wb this cycle; next state MEM_WAIT; timeout counter loads 1.
- MEM_WAIT:
  - dmem_req=1 held; stall_if, stall_id, hold_mem, bubble_wb asserted every cycle.
  - The counter increments each cycle.
  - On dmem_ack=1: bubble_wb=0 and no stall this cycle, so the MEM instruction advances; next state RUN.
  - If the counter reaches MEM_TIMEOUT without ack: set mem_error, deassert all stalls (access treated as complete, load data undefined), return to RUN.
- Redirect (RUN only, no pending memory stall): mem_redirect=1 asserts flush_if_id, flush_id_ex, flush_ex_mem for that single cycle. The PC is loaded by the datapath.
- Load-use (RUN only, no memory stall, no redirect):
  - Condition: ex_mem_to_reg=1, ex_write_reg!=0, and ((id_uses_rs and id_rs==ex_write_reg) or (id_uses_rt and id_rt==ex_write_reg)).
  - Action: stall_if=1, stall_id=1, bubble_ex=1 for exactly one cycle. The hazard clears naturally because the load then advances to MEM.
- Priority: memory wait > redirect > load-use.
  - Redirect and memory access together in MEM cannot occur by ISA. If they do, the memory stall wins and the flush fires on the ack cycle.
  - Load-use is suppressed whenever a redirect is active, because the ID instruction is being flushed.
- stall_count:
  - Increments by 1 on every cycle where stall_if=1.
  - Saturates at 2^CNT_W-1; no wrap.
- mem_error: sticky until reset.
- Reset mid-access drops dmem_req immediately; the memory side must tolerate an abandoned request.

Decomposition:
- Package pipe_ctrl_pkg: state enum {RUN, MEM_WAIT}, REG_AW default, the NOP/bubble control encoding, and jump_type encodings shared with the pipeline register banks.
- Sub-module load_use_detect: purely combinational comparator producing the load-use hazard signal. Kept separate so forwarding logic can reuse it.
- FSM, timeout counter and perf counter stay in the top module.

Test Plan:
- Load-use: ex_mem_to_reg=1, ex_write_reg=5, id_rs=5, id_uses_rs=1 -> one cycle of stall_if=stall_id=bubble_ex=1, then 0. Same with ex_write_reg=0 -> no stall.
- Zero-wait memory: mem_mem_access=1 with dmem_ack=1 same cycle -> dmem_req=1, no stall, stall_count unchanged.
- 3-cycle memory: access with ack arriving 3 cycles after request -> stalls asserted 3 cycles, bubble_wb deasserted on ack cycle, stall_count += 3.
- Redirect plus load-use in the same cycle -> only the three flush_* asserted for 1 cycle; bubble_ex=0.
- Timeout: MEM_TIMEOUT=4, ack never arrives -> mem_error=1 after 4 wait cycles, stalls drop, state RUN; mem_error stays 1 until rst_n low.
- Async reset during MEM_WAIT: rst_n low mid-cycle -> dmem_req 0 and flushes 1 immediately; stall_count=0 after release. With CNT_W=4 and 20 stalls -> stall_count saturates at 15.
